// File: rtl/data_memory_pipelined.sv
// Single-port data memory for the MEM stage: valid/ready requests, one-entry registered
// response, per-byte write enables, post-reset clear sweep. Optional DMEM_MISALIGN_TRAP_EN.
module data_memory_pipelined #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_init_cnt;
  logic [IDX_W-1:0]      w_init_cnt_next;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [IDX_W-1:0]      w_idx;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_wr_en;

  assign w_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = |req_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign init_busy = (r_state == ST_INIT);
  assign req_ready = (r_state == ST_RUN) && (!resp_valid || resp_ready);
  assign w_accept  = req_valid && req_ready && !reset;
  assign w_wr_en   = w_accept && req_we && !w_misalign;

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_next = r_init_cnt + 1'b1;
        if (r_init_cnt == LAST_IDX) begin
          w_state_next    = ST_RUN;
          w_init_cnt_next = '0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  // NOTE: the storage array has no reset; the sweep clears it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT && !reset) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (req_be[k]) r_mem[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Response register: loads on accept, drops on consume, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (w_accept) begin
      resp_valid <= 1'b1;
      resp_rdata <= (req_we || w_misalign) ? '0 : r_mem[w_idx];
      resp_err   <= w_misalign;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Self-checking bench for data_memory_pipelined: directed scenarios plus random traffic
// against a word-array reference model.
module tb_data_memory_pipelined;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_busy;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  data_memory_pipelined #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_busy  (init_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: plain word array plus the single response slot.
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  bit          m_valid;
  logic [31:0] m_rdata;
  bit          m_err;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
  endtask

  // Hold reset for n edges, then release and confirm the sweep takes exactly DEPTH edges.
  task automatic do_reset(input int n);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_init_busy",  init_busy,  1);
    check("rst_req_ready",  req_ready,  0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err",   resp_err,   0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_run = 0; m_valid = 0; m_rdata = '0; m_err = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      @(posedge clk); #1;
      if (e == DEPTH - 1) begin
        check("sweep_busy_before_end",  init_busy, 1);
        check("sweep_ready_before_end", req_ready, 0);
      end
    end
    check("sweep_busy_done",  init_busy, 0);
    check("sweep_ready_done", req_ready, 1);
    m_run = 1;
  endtask

  // One cycle: drive at negedge, check ready, update model at posedge, check response.
  task automatic step(input bit v, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input bit rr);
    bit exp_ready;
    bit mis;
    int idx;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = rr;
    #1;
    exp_ready = m_run && (!m_valid || rr);
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    if (v && exp_ready) begin
      mis = TRAP && (addr % 4 != 0);
      idx = int'((addr / 4) % DEPTH);
      m_valid = 1;
      m_err   = mis;
      m_rdata = (we || mis) ? 32'h0 : m_mem[idx];
      if (we && !mis)
        for (int k = 0; k < 4; k++)
          if (be[k]) m_mem[idx] = (m_mem[idx] & ~(32'hFF << (8*k))) | (wdata & (32'hFF << (8*k)));
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
    check("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      check("resp_rdata", resp_rdata, m_rdata);
      check("resp_err",   resp_err,   m_err);
    end
  endtask

  logic [31:0] held;

  initial begin
    idle_inputs();
    reset = 1'b1;
    do_reset(3);

    // Cleared words after the sweep.
    step(1, 0, 32'h0, 0, 0, 1);
    check("sweep_word0", resp_rdata, 0);
    step(1, 0, 32'h80, 0, 0, 1);
    step(1, 0, (DEPTH - 1) * 4, 0, 0, 1);
    check("sweep_last_word", resp_rdata, 0);

    // Byte enables.
    step(1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1);
    check("write_resp_zero", resp_rdata, 0);
    step(1, 1, 32'h100, 32'h000000AA, 4'h1, 1);
    step(1, 0, 32'h100, 0, 0, 1);
    check("byte_enable_merge", resp_rdata, 32'hDEADBEAA);

    // Back-to-back write then read of the same word.
    step(1, 1, 32'h40, 32'h12345678, 4'hF, 1);
    step(1, 0, 32'h40, 0, 0, 1);
    check("raw_next_cycle", resp_rdata, 32'h12345678);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: response held 3 cycles, consumed on the 4th with a new request.
    step(1, 0, 32'h100, 0, 0, 0);
    held = resp_rdata;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h40, 0, 0, 0);
      check("bp_rdata_stable", resp_rdata, held);
    end
    step(1, 0, 32'h40, 0, 0, 1);
    check("bp_new_response", resp_rdata, 32'h12345678);
    step(0, 0, 0, 0, 0, 1);

    // Address wrap and misalignment.
    step(1, 1, 32'h2004, 32'h55, 4'hF, 1);
    step(1, 0, 32'h4, 0, 0, 1);
    check("wrap_read", resp_rdata, 32'h55);
    step(1, 1, 32'h6, 32'hFFFFFFFF, 4'hF, 1);
    check("misalign_err", resp_err, TRAP);
    step(1, 0, 32'h4, 0, 0, 1);
    check("misalign_read", resp_rdata, TRAP ? 32'h55 : 32'hFFFFFFFF);

    // Random traffic in a small window so reads hit earlier writes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_E000) | ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
           4'($urandom), $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 0, 0, 1);

    // Reset mid-stream with a response pending.
    step(1, 1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
    check("pending_before_reset", resp_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_init_busy",  init_busy,  1);
    do_reset(1);
    step(1, 0, 32'h100, 0, 0, 1);
    check("midrst_cleared", resp_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
